// File: rtl/core_sequencer.sv
// Run-control sequencer for the 9-bit single-issue core: launch, per-instruction
// commit gating, data_ram stall timing, retire/cycle counters and watchdog.
module core_sequencer #(
   parameter int PC_W       = 9,
   parameter int CNT_W      = 16,
   parameter int MEM_LAT    = 1,
   parameter int MAX_CYCLES = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PC_W-1:0]  start_addr,
   input  logic             dec_halt,
   input  logic             dec_reg_write,
   input  logic             dec_mem_read,
   input  logic             dec_mem_write,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_load_addr,
   output logic             fetch_en,
   output logic             wb_en,
   output logic             ram_re,
   output logic             ram_we,
   output logic             busy,
   output logic             halt,
   output logic             timeout,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_MEM_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0]       LAT_CNT = 3'(MEM_LAT);
   localparam bit               HAS_LAT = (MEM_LAT > 0);
   localparam logic [CNT_W-1:0] WD_LIM  = CNT_W'(MAX_CYCLES);

   state_t           state, state_nxt;
   logic [2:0]       wait_cnt, wait_cnt_nxt;
   logic             mem_load_q, mem_load_nxt;
   logic             timeout_q, timeout_nxt;
   logic [CNT_W-1:0] instr_q, cycle_q;
   logic             retire, count_cycle, clr_cnt;
   logic             is_mem, is_load, wd_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A simultaneous read+write request is illegal and resolves to a store.
   assign is_mem  = dec_mem_read | dec_mem_write;
   assign is_load = dec_mem_read & ~dec_mem_write;
   assign wd_hit  = (cycle_q == WD_LIM);

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_load_nxt = mem_load_q;
      timeout_nxt  = timeout_q;
      retire       = 1'b0;
      count_cycle  = 1'b0;
      clr_cnt      = 1'b0;
      pc_load      = 1'b0;
      fetch_en     = 1'b0;
      wb_en        = 1'b0;
      ram_re       = 1'b0;
      ram_we       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_INIT;
               clr_cnt   = 1'b1;
            end
         end
         S_INIT: begin
            pc_load     = 1'b1;
            count_cycle = 1'b1;
            if (!start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (start) begin
               state_nxt = S_INIT;
               clr_cnt   = 1'b1;
            end else if (wd_hit) begin
               state_nxt   = S_DONE;
               timeout_nxt = 1'b1;
            end else if (dec_halt) begin
               retire      = 1'b1;
               count_cycle = 1'b1;
               state_nxt   = S_DONE;
            end else if (is_mem && HAS_LAT) begin
               ram_re       = is_load;
               ram_we       = dec_mem_write;
               count_cycle  = 1'b1;
               wait_cnt_nxt = LAT_CNT;
               mem_load_nxt = is_load;
               state_nxt    = S_MEM_WAIT;
            end else begin
               fetch_en    = 1'b1;
               wb_en       = dec_reg_write;
               ram_re      = is_load;
               ram_we      = dec_mem_write;
               retire      = 1'b1;
               count_cycle = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (start) begin
               state_nxt = S_INIT;
               clr_cnt   = 1'b1;
            end else if (wd_hit) begin
               state_nxt   = S_DONE;
               timeout_nxt = 1'b1;
            end else begin
               ram_re       = mem_load_q;
               count_cycle  = 1'b1;
               wait_cnt_nxt = wait_cnt - 3'd1;
               if (wait_cnt == 3'd1) begin
                  fetch_en  = 1'b1;
                  wb_en     = dec_reg_write;
                  retire    = 1'b1;
                  state_nxt = S_RUN;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               state_nxt = S_INIT;
               clr_cnt   = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         wait_cnt     <= 3'd0;
         mem_load_q   <= 1'b0;
         timeout_q    <= 1'b0;
         pc_load_addr <= '0;
         instr_q      <= '0;
         cycle_q      <= '0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         mem_load_q <= mem_load_nxt;
         if (start) pc_load_addr <= start_addr;
         // Counters restart on every launch and count from the first INIT cycle.
         if (clr_cnt) begin
            instr_q   <= '0;
            cycle_q   <= '0;
            timeout_q <= 1'b0;
         end else begin
            timeout_q <= timeout_nxt;
            if (retire)      instr_q <= sat_inc(instr_q);
            if (count_cycle) cycle_q <= sat_inc(cycle_q);
         end
      end
   end

   assign busy        = (state == S_INIT) || (state == S_RUN) || (state == S_MEM_WAIT);
   assign halt        = (state == S_DONE);
   assign timeout     = timeout_q;
   assign instr_count = instr_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a program-level model queues the expected
// per-cycle outputs, and a negedge monitor compares them against the DUT.
module tb_core_sequencer;

   localparam int LAT  = 2;
   localparam int MAXC = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [8:0]  start_addr;
   logic        dec_halt, dec_reg_write, dec_mem_read, dec_mem_write;
   logic        pc_load, fetch_en, wb_en, ram_re, ram_we, busy, halt, timeout;
   logic [8:0]  pc_load_addr;
   logic [15:0] instr_count, cycle_count;

   core_sequencer #(
      .PC_W(9), .CNT_W(16), .MEM_LAT(LAT), .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .dec_halt(dec_halt), .dec_reg_write(dec_reg_write),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
      .pc_load(pc_load), .pc_load_addr(pc_load_addr), .fetch_en(fetch_en),
      .wb_en(wb_en), .ram_re(ram_re), .ram_we(ram_we), .busy(busy),
      .halt(halt), .timeout(timeout), .instr_count(instr_count),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // flags = {pc_load, fetch_en, wb_en, ram_re, ram_we, busy, halt, timeout}
   typedef struct packed {
      logic [7:0]  flags;
      logic [8:0]  addr;
      logic [15:0] ic;
      logic [15:0] cc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ncyc    = 0;
   bit   expect_zero;

   // Program-level model state.
   bit       running, halted, mto;
   int       mcyc, minstr;
   logic [8:0] maddr;

   always @(negedge clk) begin
      exp_t e;
      logic [7:0] f;
      ncyc++;
      f = {pc_load, fetch_en, wb_en, ram_re, ram_we, busy, halt, timeout};
      if (expect_zero) begin
         n_tests++;
         if ({f, pc_load_addr, instr_count, cycle_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got flags=%b addr=%0h ic=%0d cc=%0d want all 0",
                     ncyc, f, pc_load_addr, instr_count, cycle_count);
         end
      end else if (q.size() > 0) begin
         e = q.pop_front();
         n_tests++;
         if (f !== e.flags) begin
            n_fail++;
            $display("FAIL strobes cyc=%0d got=%b want=%b (pc_load,fetch,wb,re,we,busy,halt,to)",
                     ncyc, f, e.flags);
         end
         n_tests++;
         if (pc_load_addr !== e.addr) begin
            n_fail++;
            $display("FAIL pc_load_addr cyc=%0d got=%0h want=%0h", ncyc, pc_load_addr, e.addr);
         end
         n_tests++;
         if (instr_count !== e.ic) begin
            n_fail++;
            $display("FAIL instr_count cyc=%0d got=%0d want=%0d", ncyc, instr_count, e.ic);
         end
         n_tests++;
         if (cycle_count !== e.cc) begin
            n_fail++;
            $display("FAIL cycle_count cyc=%0d got=%0d want=%0d", ncyc, cycle_count, e.cc);
         end
      end
   end

   function automatic exp_t status();
      exp_t e;
      e.flags = {5'b0, running, halted, mto};
      e.addr  = maddr;
      e.ic    = 16'(minstr);
      e.cc    = 16'(mcyc);
      return e;
   endfunction

   task automatic begin_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [8:0] addr, input int nhigh);
      exp_t e;
      begin_cycle();
      start = 1'b1;
      start_addr = addr;
      q.push_back(status());
      running = 1; halted = 0; mto = 0; mcyc = 0; minstr = 0; maddr = addr;
      for (int i = 1; i <= nhigh; i++) begin
         begin_cycle();
         start = (i < nhigh);
         start_addr = addr;
         e = status();
         e.flags[7] = 1'b1;
         q.push_back(e);
         mcyc++;
      end
   endtask

   // kind: 0 ALU, 1 load, 2 store, 3 halt. abort_at>0 stops the instruction
   // after that many cycles so the caller can relaunch mid-stall.
   task automatic exec(input int kind, input bit rw, input int abort_at);
      exp_t e;
      int   n;
      if (!running) return;
      n = (kind == 1 || kind == 2) ? LAT + 1 : 1;
      for (int k = 0; k < n; k++) begin
         if (abort_at > 0 && k == abort_at) return;
         begin_cycle();
         start = 1'b0;
         dec_halt = (kind == 3);
         dec_reg_write = rw;
         dec_mem_read = (kind == 1);
         dec_mem_write = (kind == 2);
         e = status();
         if (mcyc == MAXC) begin
            q.push_back(e);
            running = 0; halted = 1; mto = 1;
            return;
         end
         if (kind == 1) e.flags[4] = 1'b1;
         if (kind == 2 && k == 0) e.flags[3] = 1'b1;
         if (kind != 3 && k == n - 1) begin
            e.flags[6] = 1'b1;
            e.flags[5] = rw;
         end
         q.push_back(e);
         mcyc++;
         if (k == n - 1) begin
            minstr++;
            if (kind == 3) begin
               running = 0;
               halted = 1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         begin_cycle();
         start = 1'b0;
         {dec_halt, dec_reg_write, dec_mem_read, dec_mem_write} = 4'($urandom_range(0, 15));
         q.push_back(status());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      expect_zero = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      expect_zero = 1'b0;
      running = 0; halted = 0; mto = 0; mcyc = 0; minstr = 0; maddr = '0;
   endtask

   initial begin
      int nins, r, kind;
      bit aborted;
      rst_n = 1'b0;
      expect_zero = 1'b1;
      start = 1'b0;
      start_addr = '0;
      {dec_halt, dec_reg_write, dec_mem_read, dec_mem_write} = 4'b0;
      running = 0; halted = 0; mto = 0; mcyc = 0; minstr = 0; maddr = '0;
      #23;
      rst_n = 1'b1;
      expect_zero = 1'b0;
      idle(2);

      // Launch at 0x040, five ALU ops then halt.
      launch(9'h040, 3);
      for (int i = 0; i < 5; i++) exec(0, 1'b1, 0);
      exec(3, 1'b1, 0);
      idle(2);

      // Load then store, each stalling for the RAM latency.
      launch(9'h011, 1);
      exec(1, 1'b1, 0);
      exec(2, 1'b0, 0);
      exec(3, 1'b0, 0);
      idle(1);

      // No halt: the watchdog must end the run.
      launch(9'h1a5, 2);
      for (int i = 0; i < 60; i++) exec(0, 1'b1, 0);
      idle(2);

      // Abort during the final stall cycle of a load, then relaunch.
      launch(9'h0f0, 1);
      exec(0, 1'b1, 0);
      exec(1, 1'b1, 2);
      launch(9'h123, 2);
      exec(0, 1'b1, 0);
      exec(3, 1'b0, 0);
      idle(1);

      // Asynchronous reset in the middle of a run.
      launch(9'h077, 1);
      exec(0, 1'b1, 0);
      exec(2, 1'b0, 0);
      do_reset();
      idle(3);

      // Randomized programs.
      for (int p = 0; p < 25; p++) begin
         launch(9'($urandom_range(0, 511)), $urandom_range(1, 3));
         nins = $urandom_range(1, 12);
         aborted = 0;
         for (int i = 0; i < nins && running && !aborted; i++) begin
            r = $urandom_range(0, 9);
            kind = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            if ((kind == 1 || kind == 2) && $urandom_range(0, 7) == 0) begin
               exec(kind, 1'($urandom_range(0, 1)), $urandom_range(1, LAT));
               aborted = running;
            end else begin
               exec(kind, 1'($urandom_range(0, 1)), 0);
            end
         end
         if (!aborted) begin
            exec(3, 1'b0, 0);
            idle($urandom_range(0, 2));
         end
      end

      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
